button_press_classifier: RTL and testbench

Downstream consumer of the debounced switch level. It tracks how long each press lasts and emits one-cycle event pulses: short press, long press and, optionally, double press. It also keeps a wrapping count of classified events. Its outputs drive the control FSMs in place of the raw switch level.

---
 rtl/button_press_classifier.sv | 175 +++++++++++++++++
 tb/tb_button_press_classifier.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/button_press_classifier.sv
// button_press_classifier
//
// Classifies presses of an already-debounced switch level into one-cycle
// short / long / double event pulses and keeps a wrapping 8-bit count of
// classified events.
//
// Optional feature macro: DOUBLE_PRESS_EN
//   defined   - a release opens a GAP window of GAP_CYCLES low samples; a new
//               press inside it is reported as a double press, otherwise the
//               short press is reported when the window closes.
//   undefined - only IDLE / HELD / LONG_HELD exist, double_pulse is tied 0
//               and a short press is reported right after the release.
//
// Clock clk (rising edge), reset rst (asynchronous, active-high).

module button_press_classifier #(
  parameter int LONG_CYCLES = 50,
  parameter int GAP_CYCLES  = 20,
  parameter int CNT_W       = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_in,
  output logic       pressed,
  output logic       short_pulse,
  output logic       long_pulse,
  output logic       double_pulse,
  output logic [7:0] event_count
);

  // 3-bit state encoding; GAP and DBL_HELD are only reachable with the macro.
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    HELD      = 3'd1,
    LONG_HELD = 3'd2,
    GAP       = 3'd3,
    DBL_HELD  = 3'd4
  } state_t;

  // Counter value on the edge that takes the LONG_CYCLES-th high sample
  // (the rise sample loads 1, so the last compare value is LONG_CYCLES-1).
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_t           state_reg;
  state_t           state_next;
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;
  logic             btn_q;
  logic             rise;
  logic             short_next;
  logic             long_next;
  logic             double_next;
  logic             any_event;

`ifdef DOUBLE_PRESS_EN
  // Counter value on the edge that takes the GAP_CYCLES-th low sample after
  // the fall sample (the fall sample loads 1).
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES);
`else
  // Gap window does not exist in this build; keep the parameter referenced.
  logic [CNT_W-1:0] unused_gap_cycles;
  assign unused_gap_cycles = CNT_W'(GAP_CYCLES);
`endif

  // Only rising edges start a press; a level held across reset release
  // looks like a rise because btn_q comes out of reset low.
  assign rise      = btn_in & ~btn_q;
  assign any_event = short_next | long_next | double_next;
  assign pressed   = btn_q;

  // Previous-sample register for edge detection; also drives pressed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_q <= 1'b0;
    end else begin
      btn_q <= btn_in;
    end
  end

  // Next-state, duration counter and pulse decisions from the current sample.
  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    short_next  = 1'b0;
    long_next   = 1'b0;
    double_next = 1'b0;
    case (state_reg)
      IDLE: begin
        if (rise) begin
          state_next = HELD;
          cnt_next   = CNT_ONE;
        end
      end
      HELD: begin
        if (btn_in) begin
          if (cnt_reg == LONG_LAST) begin
            long_next  = 1'b1;
            state_next = LONG_HELD;
          end else begin
            cnt_next = cnt_reg + CNT_ONE;
          end
        end else begin
`ifdef DOUBLE_PRESS_EN
          // Defer the short decision until the gap window has elapsed.
          state_next = GAP;
          cnt_next   = CNT_ONE;
`else
          short_next = 1'b1;
          state_next = IDLE;
`endif
        end
      end
      LONG_HELD: begin
        // Already reported; the release itself produces nothing.
        if (!btn_in) begin
          state_next = IDLE;
        end
      end
`ifdef DOUBLE_PRESS_EN
      GAP: begin
        // A new press wins over the timeout on the same edge.
        if (btn_in) begin
          double_next = 1'b1;
          state_next  = DBL_HELD;
        end else if (cnt_reg == GAP_LAST) begin
          short_next = 1'b1;
          state_next = IDLE;
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end
      DBL_HELD: begin
        // The second press is consumed by the double event.
        if (!btn_in) begin
          state_next = IDLE;
        end
      end
`endif
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // State and duration counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Registered one-cycle pulses and the wrapping event counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      short_pulse  <= 1'b0;
      long_pulse   <= 1'b0;
      double_pulse <= 1'b0;
      event_count  <= 8'd0;
    end else begin
      short_pulse  <= short_next;
      long_pulse   <= long_next;
      double_pulse <= double_next;
      if (any_event) begin
        event_count <= event_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_button_press_classifier.sv
// Directed testbench for button_press_classifier (LONG_CYCLES=10,
// GAP_CYCLES=5). Inputs change on the falling edge; outputs are sampled
// 1 ns after the rising edge, so after each step the outputs reflect the
// edge that took that step's sample. Expected values are hand-computed for
// the default build and for a build with DOUBLE_PRESS_EN defined.

module tb_button_press_classifier;

  localparam int LONG_CYCLES = 10;
  localparam int GAP_CYCLES  = 5;
  localparam int CNT_W       = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_in = 1'b0;
  logic       pressed;
  logic       short_pulse;
  logic       long_pulse;
  logic       double_pulse;
  logic [7:0] event_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  button_press_classifier #(
    .LONG_CYCLES(LONG_CYCLES),
    .GAP_CYCLES (GAP_CYCLES),
    .CNT_W      (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .btn_in      (btn_in),
    .pressed     (pressed),
    .short_pulse (short_pulse),
    .long_pulse  (long_pulse),
    .double_pulse(double_pulse),
    .event_count (event_count)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Present one sample and wait until just after the edge that takes it.
  task automatic drive(input logic b);
    @(negedge clk);
    btn_in = b;
    @(posedge clk);
    #1;
  endtask

  // One sample plus a check of every output against hand-computed values.
  task automatic step(input string tag, input logic b, input logic es,
                      input logic el, input logic ed, input logic [7:0] ec);
    drive(b);
    chk({tag, " pressed"}, {7'd0, pressed},      {7'd0, b});
    chk({tag, " short"},   {7'd0, short_pulse},  {7'd0, es});
    chk({tag, " long"},    {7'd0, long_pulse},   {7'd0, el});
    chk({tag, " double"},  {7'd0, double_pulse}, {7'd0, ed});
    chk({tag, " count"},   event_count,          ec);
  endtask

  // Reset with btn_in held at b; rst is released just after a rising edge
  // so the next edge is the first sample.
  task automatic do_reset(input logic b);
    @(negedge clk);
    btn_in = b;
    rst    = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // One complete short press, including the gap window when it exists.
  task automatic short_press();
    drive(1'b1);
    drive(1'b0);
`ifdef DOUBLE_PRESS_EN
    repeat (GAP_CYCLES) drive(1'b0);
`endif
  endtask

  initial begin
    // Reset held with the button high: everything stays cleared.
    rst    = 1'b1;
    btn_in = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst pressed", {7'd0, pressed},      8'd0);
    chk("rst short",   {7'd0, short_pulse},  8'd0);
    chk("rst long",    {7'd0, long_pulse},   8'd0);
    chk("rst double",  {7'd0, double_pulse}, 8'd0);
    chk("rst count",   event_count,          8'd0);
    rst = 1'b0;

    // Level high at reset release counts as a rise; 14 high samples give a
    // long pulse after the 10th and nothing on release.
    for (int i = 1; i <= 9; i++) step("long.pre", 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
    step("long.tenth", 1'b1, 1'b0, 1'b1, 1'b0, 8'd1);
    for (int i = 11; i <= 14; i++) step("long.post", 1'b1, 1'b0, 1'b0, 1'b0, 8'd1);
    for (int i = 0; i < 3; i++) step("long.release", 1'b0, 1'b0, 1'b0, 1'b0, 8'd1);

    // Short press: 3 high then low.
    do_reset(1'b0);
    for (int i = 0; i < 3; i++) step("short.hold", 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
`ifdef DOUBLE_PRESS_EN
    step("short.fall", 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    for (int i = 1; i <= 4; i++) step("short.gap", 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    step("short.timeout", 1'b0, 1'b1, 1'b0, 1'b0, 8'd1);
    for (int i = 0; i < 2; i++) step("short.after", 1'b0, 1'b0, 1'b0, 1'b0, 8'd1);
`else
    step("short.fall", 1'b0, 1'b1, 1'b0, 1'b0, 8'd1);
    for (int i = 0; i < 6; i++) step("short.after", 1'b0, 1'b0, 1'b0, 1'b0, 8'd1);
`endif

    // Boundary: 9 high samples is still a short press.
    do_reset(1'b0);
    for (int i = 0; i < 9; i++) step("nine.hold", 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
`ifdef DOUBLE_PRESS_EN
    step("nine.fall", 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    for (int i = 1; i <= 4; i++) step("nine.gap", 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    step("nine.timeout", 1'b0, 1'b1, 1'b0, 1'b0, 8'd1);
`else
    step("nine.fall", 1'b0, 1'b1, 1'b0, 1'b0, 8'd1);
`endif

    // High 3, low 2, high 3, then low.
    do_reset(1'b0);
    for (int i = 0; i < 3; i++) step("dbl.first", 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
`ifdef DOUBLE_PRESS_EN
    step("dbl.fall", 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    step("dbl.gap", 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    step("dbl.rise2", 1'b1, 1'b0, 1'b0, 1'b1, 8'd1);
    for (int i = 0; i < 2; i++) step("dbl.second", 1'b1, 1'b0, 1'b0, 1'b0, 8'd1);
    for (int i = 0; i < 7; i++) step("dbl.release", 1'b0, 1'b0, 1'b0, 1'b0, 8'd1);

    // Second press on the last low edge of the window still wins.
    do_reset(1'b0);
    for (int i = 0; i < 3; i++) step("dbl5.first", 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
    step("dbl5.fall", 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    for (int i = 1; i <= 4; i++) step("dbl5.gap", 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    step("dbl5.rise2", 1'b1, 1'b0, 1'b0, 1'b1, 8'd1);
    step("dbl5.release", 1'b0, 1'b0, 1'b0, 1'b0, 8'd1);
`else
    step("dbl.fall", 1'b0, 1'b1, 1'b0, 1'b0, 8'd1);
    step("dbl.gap", 1'b0, 1'b0, 1'b0, 1'b0, 8'd1);
    for (int i = 0; i < 3; i++) step("dbl.second", 1'b1, 1'b0, 1'b0, 1'b0, 8'd1);
    step("dbl.release", 1'b0, 1'b1, 1'b0, 1'b0, 8'd2);
    for (int i = 0; i < 6; i++) step("dbl.after", 1'b0, 1'b0, 1'b0, 1'b0, 8'd2);
`endif

    // Reset in the middle of a press discards it and clears the count.
    do_reset(1'b0);
    short_press();
    chk("midrst precount", event_count, 8'd1);
    for (int i = 0; i < 5; i++) step("midrst.hold", 1'b1, 1'b0, 1'b0, 1'b0, 8'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst pressed", {7'd0, pressed},     8'd0);
    chk("midrst short",   {7'd0, short_pulse}, 8'd0);
    chk("midrst long",    {7'd0, long_pulse},  8'd0);
    chk("midrst count",   event_count,         8'd0);
    btn_in = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 12; i++) step("midrst.after", 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);

    // 256 short presses wrap the event counter back to 0.
    do_reset(1'b0);
    repeat (255) short_press();
    chk("wrap 255", event_count, 8'd255);
    short_press();
    chk("wrap 256", event_count, 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
